periph_zone_decoder: RTL and testbench
======================================

PERIPH_ZONE_DECODER -- requirements
Module: periph_zone_decoder

Interface
REQ-001 Parameter: N_CH, 5, number of analog channels decoded.
REQ-002 Parameter: ADC_W, 12, sample width in bits.
REQ-003 Parameter: T_MID, 12'h600, lower zone threshold (IDLE/MID boundary).
REQ-004 Parameter: T_HI, 12'hD00, upper zone threshold (MID/HIGH boundary).
REQ-005 Parameter: HYST, 64, hysteresis margin in LSBs applied around each threshold.
REQ-006 Parameter: DB_SAMPLES, 8, consecutive agreeing samples required to accept a zone change (range 1..255).
REQ-007 Parameter: REP_DELAY, 200, samples held before first auto-repeat; REP_RATE, 50, samples between repeats (range 1..65535).
REQ-008 Port: clk  in  1  system clock, all state on rising edge.
REQ-009 Port: resetN  in  1  asynchronous active-low reset.
REQ-010 Port: adc_data  in  N_CH*ADC_W  packed samples; channel c occupies bits [c*ADC_W +: ADC_W].
REQ-011 Port: adc_valid  in  1  single-cycle strobe; adc_data is valid only in that cycle.
REQ-012 Port: zone_hi  out  N_CH  debounced stable zone == HIGH.
REQ-013 Port: zone_mid  out  N_CH  debounced stable zone == MID.
REQ-014 Port: press_p  out  N_CH  one-cycle pulse on press (and on repeat, if compiled in).
REQ-015 Port: release_p  out  N_CH  one-cycle pulse on return to IDLE.

Function
REQ-016 Each channel SHALL hold a stable zone in {IDLE, MID, HIGH}; zone_hi/zone_mid are registered decodes of it, never both 1.
REQ-017 Raw classification SHALL occur only in adc_valid cycles; with adc_valid low all counters and zones hold.
REQ-018 Hysteresis: a threshold the stable zone lies below SHALL use T+HYST (sample > T+HYST crosses upward); a threshold it lies above SHALL use T-HYST (sample < T-HYST crosses downward); otherwise raw zone equals stable zone.
REQ-019 T+HYST SHALL saturate at 2^ADC_W-1 and T-HYST at 0; computed at ADC_W+1 bits, no wrap.
REQ-020 Debounce per channel: candidate zone + 8-bit count; raw == stable -> count cleared; raw != stable and raw == candidate -> count+1; raw != stable and raw != candidate -> candidate := raw, count := 1.
REQ-021 When count reaches DB_SAMPLES, stable SHALL become candidate on that same adc_valid edge and count SHALL clear; DB_SAMPLES=1 gives one-sample latency.
REQ-022 Zone outputs SHALL update on the clock edge that registers the adc_valid sample completing debounce (registered, 0 extra cycles).
REQ-023 press_p[c] SHALL pulse for exactly one clock, same edge as zone update, when stable goes IDLE -> MID or IDLE -> HIGH.
REQ-024 release_p[c] SHALL pulse one clock when stable goes MID/HIGH -> IDLE; direct MID <-> HIGH changes SHALL produce no pulse.
REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 resetN low SHALL asynchronously force all stable zones and candidates to IDLE, counts and repeat timers to 0, all outputs to 0.
REQ-027 Reset mid-debounce or mid-hold SHALL discard progress; no press_p/release_p pulse on reset assertion or release.

Configuration
REQ-028 Macro PERIPH_AUTOREPEAT_EN defined: per-channel 16-bit repeat timer counts adc_valid samples while stable != IDLE; press_p re-pulses after REP_DELAY samples, then every REP_RATE samples; timer clears on IDLE or on MID <-> HIGH change.
REQ-029 Macro undefined: no repeat timer logic; exactly one press_p per IDLE exit; REP_DELAY/REP_RATE ignored.

Verification
REQ-030 DB_SAMPLES=8, ch0 samples 12'hE00 x7 then 12'h000 -> zone_hi[0] stays 0, no press_p.
REQ-031 ch0 12'hE00 x8 -> zone_hi[0]=1 and one press_p[0] on 8th valid edge; then 12'h000 x8 -> release_p[0] once, zone_hi[0]=0.
REQ-032 HYST=64, ch1 stable MID, samples 12'hCE0 x20 -> stays MID (below T_HI+HYST=12'hD40); samples 12'hD41 x8 -> HIGH, no press_p.
REQ-033 ch2 and ch4 cross to MID on same sample stream -> press_p[2] and press_p[4] asserted in same cycle; ch3 unaffected.
REQ-034 resetN pulsed low after 5 of 8 debounce samples -> outputs 0; 3 more HIGH samples after reset -> no zone change.
REQ-035 PERIPH_AUTOREPEAT_EN, REP_DELAY=4, REP_RATE=2, ch0 held HIGH -> press_p[0] at acceptance, +4, +6, +8 samples; without macro -> single pulse.

Source files
------------

// File: rtl/periph_zone_decoder.sv
// Per-channel 3-zone ADC classifier with hysteresis, debounce and press/release pulses.
// Latency: zone/pulse outputs registered on the adc_valid edge that completes debounce.
// Backpressure: none; samples are taken only on adc_valid and all state holds otherwise.
// Optional feature: define PERIPH_AUTOREPEAT_EN to add per-channel press auto-repeat.
module periph_zone_decoder #(
  parameter int N_CH       = 5,
  parameter int ADC_W      = 12,
  parameter int T_MID      = 'h600,
  parameter int T_HI       = 'hD00,
  parameter int HYST       = 64,
  parameter int DB_SAMPLES = 8,
  parameter int REP_DELAY  = 200,
  parameter int REP_RATE   = 50
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [N_CH*ADC_W-1:0] adc_data,
  input  logic                  adc_valid,
  output logic [N_CH-1:0]       zone_hi,
  output logic [N_CH-1:0]       zone_mid,
  output logic [N_CH-1:0]       press_p,
  output logic [N_CH-1:0]       release_p
);

  typedef enum logic [1:0] {Z_IDLE = 2'd0, Z_MID = 2'd1, Z_HIGH = 2'd2} zone_e;

  // Hysteresis thresholds, saturated to the sample range so they never wrap.
  localparam int MAXV     = (1 << ADC_W) - 1;
  localparam int MID_UP_I = (T_MID + HYST > MAXV) ? MAXV : T_MID + HYST;
  localparam int MID_DN_I = (T_MID < HYST) ? 0 : T_MID - HYST;
  localparam int HI_UP_I  = (T_HI + HYST > MAXV) ? MAXV : T_HI + HYST;
  localparam int HI_DN_I  = (T_HI < HYST) ? 0 : T_HI - HYST;

  localparam logic [ADC_W:0] MID_UP = (ADC_W+1)'(MID_UP_I);
  localparam logic [ADC_W:0] MID_DN = (ADC_W+1)'(MID_DN_I);
  localparam logic [ADC_W:0] HI_UP  = (ADC_W+1)'(HI_UP_I);
  localparam logic [ADC_W:0] HI_DN  = (ADC_W+1)'(HI_DN_I);
  localparam logic [8:0]     DB_N   = 9'(DB_SAMPLES);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [ADC_W:0] smp;
    zone_e          stable_q, stable_d, cand_q, cand_d, raw;
    logic [7:0]     cnt_q, cnt_d;
    logic [8:0]     cnt_inc;
    logic           above_mid, above_hi, accept;
    logic           press_d, release_d, press_q, release_q;
    logic           rep_fire;

    assign smp = {1'b0, adc_data[c*ADC_W +: ADC_W]};

    // Classify the sample against hysteresis-shifted thresholds, then debounce it.
    always_comb begin
      stable_d  = stable_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      cnt_inc   = '0;
      accept    = 1'b0;
      above_mid = (stable_q == Z_IDLE) ? (smp > MID_UP) : !(smp < MID_DN);
      above_hi  = (stable_q == Z_HIGH) ? !(smp < HI_DN) : (smp > HI_UP);
      raw       = above_hi ? Z_HIGH : (above_mid ? Z_MID : Z_IDLE);
      if (adc_valid) begin
        if (raw == stable_q) begin
          cnt_d = '0;
        end else begin
          if (raw == cand_q) begin
            cnt_inc = {1'b0, cnt_q} + 9'd1;
          end else begin
            cand_d  = raw;
            cnt_inc = 9'd1;
          end
          if (cnt_inc >= DB_N) begin
            accept   = 1'b1;
            stable_d = raw;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      press_d   = (accept && stable_q == Z_IDLE) || rep_fire;
      release_d = accept && raw == Z_IDLE;
    end

`ifdef PERIPH_AUTOREPEAT_EN
    localparam logic [16:0] REP_FIRST = 17'(REP_DELAY);
    localparam logic [16:0] REP_NEXT  = 17'(REP_DELAY) + 17'(REP_RATE);
    logic [15:0] rep_q, rep_d;
    logic [16:0] rep_inc;

    // Repeat timer: restarts on any zone change, fires at REP_DELAY then every REP_RATE.
    always_comb begin
      rep_d    = rep_q;
      rep_fire = 1'b0;
      rep_inc  = {1'b0, rep_q} + 17'd1;
      if (adc_valid) begin
        if (accept) begin
          rep_d = '0;
        end else if (stable_q != Z_IDLE) begin
          if (rep_inc == REP_FIRST) begin
            rep_fire = 1'b1;
            rep_d    = rep_inc[15:0];
          end else if (rep_inc == REP_NEXT) begin
            rep_fire = 1'b1;
            rep_d    = REP_FIRST[15:0];
          end else begin
            rep_d = rep_inc[15:0];
          end
        end
      end
    end

    // Repeat timer register.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) rep_q <= '0;
      else         rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Zone, debounce and pulse state.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        stable_q  <= Z_IDLE;
        cand_q    <= Z_IDLE;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        cand_q    <= cand_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign zone_hi[c]   = (stable_q == Z_HIGH);
    assign zone_mid[c]  = (stable_q == Z_MID);
    assign press_p[c]   = press_q;
    assign release_p[c] = release_q;
  end

endmodule

// File: tb/tb_periph_zone_decoder.sv
module tb_periph_zone_decoder;
  localparam logic [11:0] LO = 12'h000;
  localparam logic [11:0] MD = 12'h900;
  localparam logic [11:0] HI = 12'hE00;

  logic        clk = 1'b0;
  logic        resetN;
  logic [59:0] adc_data;
  logic        adc_valid;
  logic [4:0]  zone_hi, zone_mid, press_p, release_p;
  logic [4:0]  zone_hi2, zone_mid2, press_p2, release_p2;

  always #5 clk = ~clk;

  // Main instance: repeat disabled in practice (huge delay) so the table is build-independent.
  periph_zone_decoder #(.REP_DELAY(60000), .REP_RATE(60000)) u_dut (
    .clk(clk), .resetN(resetN), .adc_data(adc_data), .adc_valid(adc_valid),
    .zone_hi(zone_hi), .zone_mid(zone_mid), .press_p(press_p), .release_p(release_p));

  // Second instance for the short auto-repeat scenario.
  periph_zone_decoder #(.REP_DELAY(4), .REP_RATE(2)) u_dut_rep (
    .clk(clk), .resetN(resetN), .adc_data(adc_data), .adc_valid(adc_valid),
    .zone_hi(zone_hi2), .zone_mid(zone_mid2), .press_p(press_p2), .release_p(release_p2));

  typedef struct {
    logic [59:0] d;
    logic        v;
    logic [4:0]  hi, mid, pr, rl;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [59:0] pk(input logic [11:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic add(input int n, input logic [59:0] d, input logic v,
                     input logic [4:0] hi, mid, pr, rl, input string nm);
    vec_t e;
    e.d = d; e.v = v; e.hi = hi; e.mid = mid; e.pr = pr; e.rl = rl; e.nm = nm;
    repeat (n) tbl.push_back(e);
  endtask

  task automatic check(input string nm, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b_%b_%b_%b required %b_%b_%b_%b", nm,
               got[19:15], got[14:10], got[9:5], got[4:0],
               exp[19:15], exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  task automatic drive(input logic [59:0] d, input logic v);
    @(negedge clk);
    adc_data  = d;
    adc_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    adc_valid = 1'b0;
    resetN    = 1'b0;
    #1;
    check("rst_async", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    logic exp_rep;

    // ch0: short burst then abort, full press and release, valid-low hold.
    add(7, pk(HI,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "a_short7");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "a_abort");
    add(7, pk(HI,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "b_deb");
    add(1, pk(HI,LO,LO,LO,LO), 1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, "b_accept");
    add(1, pk(HI,LO,LO,LO,LO), 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, "b_hold");
    add(3, pk(LO,LO,LO,LO,LO), 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, "b_novalid");
    add(7, pk(LO,LO,LO,LO,LO), 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, "b_reldeb");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00001, "b_release");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "b_quiet");
    // ch1: MID, hysteresis around T_HI (D40 up / CC0 down), MID->HIGH without press.
    add(7, pk(LO,MD,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "c_deb");
    add(1, pk(LO,MD,LO,LO,LO), 1, 5'b00000, 5'b00010, 5'b00010, 5'b00000, "c_mid");
    add(20, pk(LO,12'hCE0,LO,LO,LO), 1, 5'b00000, 5'b00010, 5'b00000, 5'b00000, "c_hyst_up");
    add(7, pk(LO,12'hD41,LO,LO,LO), 1, 5'b00000, 5'b00010, 5'b00000, 5'b00000, "c_deb_hi");
    add(1, pk(LO,12'hD41,LO,LO,LO), 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, "c_high");
    add(8, pk(LO,12'hCC0,LO,LO,LO), 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, "c_hyst_dn");
    add(7, pk(LO,LO,LO,LO,LO), 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, "c_deb_idle");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00010, "c_release");
    // ch2+ch4 together; ch3 parked exactly on T_MID+HYST stays IDLE.
    add(7, pk(LO,LO,MD,12'h640,MD), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "d_deb");
    add(1, pk(LO,LO,MD,12'h640,MD), 1, 5'b00000, 5'b10100, 5'b10100, 5'b00000, "d_press24");
    add(8, pk(LO,LO,12'h5C0,12'h640,12'h5C0), 1, 5'b00000, 5'b10100, 5'b00000, 5'b00000, "d_hyst_dn");
    add(7, pk(LO,LO,LO,12'h640,LO), 1, 5'b00000, 5'b10100, 5'b00000, 5'b00000, "d_deb_idle");
    add(1, pk(LO,LO,LO,12'h640,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b10100, "d_release24");
    // ch0: debounce spread across valid-low gaps, then MID->HIGH->MID with no pulses.
    add(4, pk(MD,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "e_deb4");
    add(5, pk(MD,LO,LO,LO,LO), 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "e_gap");
    add(3, pk(MD,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "e_deb7");
    add(1, pk(MD,LO,LO,LO,LO), 1, 5'b00000, 5'b00001, 5'b00001, 5'b00000, "e_press");
    add(7, pk(HI,LO,LO,LO,LO), 1, 5'b00000, 5'b00001, 5'b00000, 5'b00000, "f_deb_hi");
    add(1, pk(HI,LO,LO,LO,LO), 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, "f_mid_to_hi");
    add(7, pk(MD,LO,LO,LO,LO), 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, "f_deb_mid");
    add(1, pk(MD,LO,LO,LO,LO), 1, 5'b00000, 5'b00001, 5'b00000, 5'b00000, "f_hi_to_mid");
    add(7, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00001, 5'b00000, 5'b00000, "f_deb_idle");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00001, "f_release");
    // ch3: candidate switches MID->HIGH mid-debounce, count restarts at 1.
    add(4, pk(LO,LO,LO,MD,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "g_mid4");
    add(7, pk(LO,LO,LO,HI,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, "g_hi7");
    add(1, pk(LO,LO,LO,HI,LO), 1, 5'b01000, 5'b00000, 5'b01000, 5'b00000, "g_press_hi");
    add(7, pk(LO,LO,LO,LO,LO), 1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, "g_deb_idle");
    add(1, pk(LO,LO,LO,LO,LO), 1, 5'b00000, 5'b00000, 5'b00000, 5'b01000, "g_release");

    // Power-on reset.
    resetN    = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    check("reset_exit", {zone_hi, zone_mid, press_p, release_p}, 20'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].d, tbl[i].v);
      check($sformatf("%s[%0d]", tbl[i].nm, i), {zone_hi, zone_mid, press_p, release_p},
            {tbl[i].hi, tbl[i].mid, tbl[i].pr, tbl[i].rl});
    end

    // Reset mid-debounce (ch0 at 5/8) with ch1 already MID; progress must be lost.
    for (int i = 0; i < 3; i++) begin
      drive(pk(LO,MD,LO,LO,LO), 1'b1);
      check("r_pre_mid", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(pk(HI,MD,LO,LO,LO), 1'b1);
      check("r_pre_hi", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
    end
    drive(pk(HI,MD,LO,LO,LO), 1'b1);
    check("r_ch1_mid", {zone_hi, zone_mid, press_p, release_p},
          {5'b00000, 5'b00010, 5'b00010, 5'b00000});
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(pk(HI,MD,LO,LO,LO), 1'b1);
      check("r_post", {zone_hi, zone_mid, press_p, release_p}, 20'h0);
    end

    // Auto-repeat: ch0 held HIGH on both instances from a clean reset.
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(pk(HI,LO,LO,LO,LO), 1'b1);
      check($sformatf("rep_deb%0d", i), {zone_hi, press_p, zone_hi2, press_p2},
            (i == 8) ? {5'b00001, 5'b00001, 5'b00001, 5'b00001} : 20'h0);
    end
    for (int k = 1; k <= 10; k++) begin
`ifdef PERIPH_AUTOREPEAT_EN
      exp_rep = (k == 4) || (k > 4 && (k % 2) == 0);
`else
      exp_rep = 1'b0;
`endif
      drive(pk(HI,LO,LO,LO,LO), 1'b1);
      check($sformatf("rep_hold%0d", k), {zone_hi, press_p, zone_hi2, press_p2},
            {5'b00001, 5'b00000, 5'b00001, 4'b0000, exp_rep});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
